control_timp: RTL and testbench
===============================

CONTROL_TIMP -- requirements
Module: control_timp

Interface
REQ-001 The block SHALL have the parameter HOLD_CYCLES, default 2, giving the post-load settle cycles before the response (range 1..7).
REQ-002 The block SHALL have the parameter MAX_ORE, default 23, giving the highest legal hour value.
REQ-003 The block SHALL have the parameter MAX_MIN, default 59, giving the highest legal minute value.
REQ-004 The block SHALL have the port clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have the port reset, input, 1 bit: synchronous active-low reset.
REQ-006 The block SHALL have the ports req1 and req2, input, 1 bit each: load requests from requesters 1 and 2.
REQ-007 The block SHALL have the ports ore1 and ore2, input, 5 bits each, and min1 and min2, input, 6 bits each: the requested time.
REQ-008 The block SHALL have the ports ack1, ack2, nack1 and nack2, output, 1 bit each: one-cycle response pulses.
REQ-009 The block SHALL have the ports load_1 and load_2, output, 1 bit each: load strobes to the time counter.
REQ-010 The block SHALL have the ports timp_ore1 and timp_ore2, output, 5 bits each, and timp_minute1 and timp_minute2, output, 6 bits each: latched load values to the counter.
REQ-011 The block SHALL have the ports out_ore, input, 5 bits, and out_minute, input, 6 bits: the counter's current time.
REQ-012 The block SHALL have the ports alarm_set, input, 1 bit, alarm_ore, input, 5 bits, and alarm_minute, input, 6 bits: the go-home time programming port.
REQ-013 The block SHALL have the port alarm, output, 1 bit: a one-cycle go-home pulse.
REQ-014 The block SHALL have the port busy, output, 1 bit: high whenever the state machine is not in IDLE.

Function
REQ-015 The FSM SHALL have the states IDLE, LOAD, HOLD and RESP; busy=1 outside IDLE.
REQ-016 In IDLE, when exactly one reqN=1, that requester SHALL be granted.
REQ-017 In IDLE, when both requests are high, the grant SHALL go to the requester not granted last (round-robin); after reset, requester 1 SHALL win the first tie.
REQ-018 On grant, oreN/minN SHALL be captured into timp_oreN/timp_minuteN, and the request SHALL be valid if and only if ore<=MAX_ORE and min<=MAX_MIN.
REQ-019 For a valid grant: IDLE->LOAD; in LOAD, load_N=1 for exactly one cycle, then LOAD->HOLD.
REQ-020 For an invalid grant: IDLE->RESP directly; no load strobe; the timp_* outputs SHALL retain their previous value.
REQ-021 HOLD SHALL last exactly HOLD_CYCLES cycles, then go to RESP.
REQ-022 In RESP, ackN (valid) or nackN (invalid) SHALL be 1 for one cycle, then RESP->IDLE.
REQ-023 Grant-to-ack latency SHALL be 2+HOLD_CYCLES cycles (4 at default); grant-to-nack latency SHALL be 1 cycle.
REQ-024 load_1 and load_2 SHALL never be high in the same cycle, and at most one ack/nack SHALL be high per cycle.
REQ-025 Requests arriving while busy=1 SHALL be ignored.
REQ-026 A requester holding req across its own ack SHALL be re-arbitrated in IDLE like any new request.
REQ-027 req or ore/min changes after grant SHALL have no effect on the transaction in progress.
REQ-028 alarm_set=1 SHALL latch alarm_ore/alarm_minute only if both are in range; an out-of-range value SHALL be dropped and the old alarm time kept.
REQ-029 alarm SHALL pulse for one cycle in the cycle after the match (out_ore,out_minute)==alarm time becomes true (rising edge of match only).
REQ-030 A match that remains true on consecutive cycles SHALL give one pulse.
REQ-031 alarm SHALL be suppressed while the state is LOAD or HOLD.

Reset
REQ-032 With reset=0 at a clock edge: state=IDLE, round-robin pointer=requester 1, all ack/nack/load/alarm/busy outputs=0, timp_*=0.
REQ-033 Reset SHALL set the alarm time to 17:00 and clear the match history.
REQ-034 Reset asserted mid-transaction SHALL abort it with no ack/nack emitted.
REQ-035 Reset SHALL take priority over every other input.

Configuration
REQ-036 With macro ALARM_EN defined, the alarm logic of REQ-028 to REQ-031 SHALL be compiled in.
REQ-037 Without ALARM_EN, alarm SHALL be tied 0, alarm_set/alarm_ore/alarm_minute SHALL be ignored, and no alarm registers SHALL exist; the port list SHALL stay unchanged.

Verification
REQ-038 Load path: req1=1 with 08:30 -> load_1 one cycle after grant with timp_ore1=8, timp_minute1=30; ack1 four cycles after grant.
REQ-039 Tie arbitration: req1=req2=1 from reset -> requester 1 served first; both held -> requester 2 served next; load_1/load_2 never both high.
REQ-040 Invalid request: req2=1 with 24:10, then 12:60 -> nack2 one cycle after each grant; no load_2; timp_*2 unchanged.
REQ-041 Alarm (ALARM_EN defined): alarm_set with 16:45, counter out stepping 16:44->16:45->16:46 -> exactly one alarm pulse; 25:00 programmed -> rejected, alarm time stays 16:45.
REQ-042 Reset abort: reset=0 during HOLD -> busy=0, no ack, timp_*=0 next cycle; a fresh req1 is then served normally.
REQ-043 Without ALARM_EN: any stimulus -> alarm stays 0.

Source files
------------

// File: rtl/control_timp.sv
// control_timp: arbitrates two time-load requesters, validates and strobes the time into a counter, optional go-home alarm
// Ports: clock/reset (sync active-low); req1/req2 with ore1/min1, ore2/min2 request a load;
// load_1/load_2 strobe timp_ore1/timp_minute1 or timp_ore2/timp_minute2 into the counter;
// ack1/ack2/nack1/nack2 are one-cycle responses; busy is high outside IDLE;
// out_ore/out_minute is the counter's time, compared against the alarm time set via alarm_set/alarm_ore/alarm_minute.
// Macro ALARM_EN compiles in the alarm logic; without it alarm is tied low and the alarm inputs are ignored.
module control_timp #(
  parameter int HOLD_CYCLES = 2,
  parameter int MAX_ORE = 23,
  parameter int MAX_MIN = 59
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req1,
  input  logic       req2,
  input  logic [4:0] ore1,
  input  logic [4:0] ore2,
  input  logic [5:0] min1,
  input  logic [5:0] min2,
  output logic       ack1,
  output logic       ack2,
  output logic       nack1,
  output logic       nack2,
  output logic       load_1,
  output logic       load_2,
  output logic [4:0] timp_ore1,
  output logic [4:0] timp_ore2,
  output logic [5:0] timp_minute1,
  output logic [5:0] timp_minute2,
  input  logic [4:0] out_ore,
  input  logic [5:0] out_minute,
  input  logic       alarm_set,
  input  logic [4:0] alarm_ore,
  input  logic [5:0] alarm_minute,
  output logic       alarm,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, LOAD, HOLD, RESP} state_t;
  localparam logic [4:0] ORE_HI = 5'(MAX_ORE);
  localparam logic [5:0] MIN_HI = 6'(MAX_MIN);
  state_t state;
  logic prio2, who2, pick2, grant, ok;
  logic [2:0] cnt;
  logic [4:0] g_ore;
  logic [5:0] g_min;
  // prio2 set means requester 2 wins the next tie (requester 1 was granted last)
  always_comb begin
    pick2 = req2 & (~req1 | prio2);
    grant = req1 | req2;
    g_ore = pick2 ? ore2 : ore1;
    g_min = pick2 ? min2 : min1;
    ok = (g_ore <= ORE_HI) && (g_min <= MIN_HI);
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      prio2 <= 1'b0;
      who2 <= 1'b0;
      cnt <= '0;
      busy <= 1'b0;
      {load_1, load_2, ack1, ack2, nack1, nack2} <= '0;
      timp_ore1 <= '0;
      timp_ore2 <= '0;
      timp_minute1 <= '0;
      timp_minute2 <= '0;
    end else begin
      {load_1, load_2, ack1, ack2, nack1, nack2} <= '0;
      case (state)
        IDLE: if (grant) begin
          who2 <= pick2;
          prio2 <= ~pick2;
          busy <= 1'b1;
          if (ok) begin
            state <= LOAD;
            load_1 <= ~pick2;
            load_2 <= pick2;
            if (pick2) begin
              timp_ore2 <= g_ore;
              timp_minute2 <= g_min;
            end else begin
              timp_ore1 <= g_ore;
              timp_minute1 <= g_min;
            end
          end else begin
            state <= RESP;
            nack1 <= ~pick2;
            nack2 <= pick2;
          end
        end
        LOAD: begin
          state <= HOLD;
          cnt <= 3'(HOLD_CYCLES - 1);
        end
        HOLD: if (cnt == 3'd0) begin
          state <= RESP;
          ack1 <= ~who2;
          ack2 <= who2;
        end else cnt <= cnt - 3'd1;
        default: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end
`ifdef ALARM_EN
  logic [4:0] al_ore;
  logic [5:0] al_min;
  logic match, match_q;
  assign match = (out_ore == al_ore) && (out_minute == al_min);
  // only the rising edge of the match fires, and never while a load is settling
  always_ff @(posedge clock) begin
    if (!reset) begin
      al_ore <= 5'd17;
      al_min <= 6'd0;
      match_q <= 1'b0;
      alarm <= 1'b0;
    end else begin
      if (alarm_set && alarm_ore <= ORE_HI && alarm_minute <= MIN_HI) begin
        al_ore <= alarm_ore;
        al_min <= alarm_minute;
      end
      match_q <= match;
      alarm <= match & ~match_q & ~(state == LOAD || state == HOLD);
    end
  end
`else
  logic unused_alarm;
  assign unused_alarm = &{1'b0, alarm_set, alarm_ore, alarm_minute, out_ore, out_minute};
  assign alarm = 1'b0;
`endif
endmodule

// File: tb/tb_control_timp.sv
// tb_control_timp: directed and random stimulus against a transaction-timeline reference model
module tb_control_timp;
  localparam int H = 2;
  logic clock = 1'b0;
  logic reset, req1, req2, alarm_set;
  logic [4:0] ore1, ore2, out_ore, alarm_ore;
  logic [5:0] min1, min2, out_minute, alarm_minute;
  logic ack1, ack2, nack1, nack2, load_1, load_2, alarm, busy;
  logic [4:0] timp_ore1, timp_ore2;
  logic [5:0] timp_minute1, timp_minute2;
  int errors = 0, checks = 0, cyc = 0;
  int g_t = -100, m_lat = 1, m_who = 1;
  bit m_valid = 0, last1 = 0;
  logic [4:0] e_o1 = '0, e_o2 = '0;
  logic [5:0] e_m1 = '0, e_m2 = '0;
`ifdef ALARM_EN
  logic [4:0] a_o = 5'd17;
  logic [5:0] a_m = 6'd0;
  bit prev_m = 0, e_alarm = 0;
`endif

  control_timp #(.HOLD_CYCLES(H)) dut (
    .clock(clock), .reset(reset), .req1(req1), .req2(req2),
    .ore1(ore1), .ore2(ore2), .min1(min1), .min2(min2),
    .ack1(ack1), .ack2(ack2), .nack1(nack1), .nack2(nack2),
    .load_1(load_1), .load_2(load_2),
    .timp_ore1(timp_ore1), .timp_ore2(timp_ore2),
    .timp_minute1(timp_minute1), .timp_minute2(timp_minute2),
    .out_ore(out_ore), .out_minute(out_minute),
    .alarm_set(alarm_set), .alarm_ore(alarm_ore), .alarm_minute(alarm_minute),
    .alarm(alarm), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  // Inputs of the current cycle decide what is visible from the next cycle on.
  task automatic model_step();
    bit p2, ok;
    logic [4:0] o;
    logic [5:0] m;
`ifdef ALARM_EN
    bit mt;
    if (!reset) begin
      a_o = 5'd17;
      a_m = 6'd0;
      prev_m = 0;
      e_alarm = 0;
    end else begin
      mt = (out_ore == a_o) && (out_minute == a_m);
      e_alarm = mt && !prev_m && !(m_valid && cyc >= g_t + 1 && cyc <= g_t + 1 + H);
      prev_m = mt;
      if (alarm_set && alarm_ore <= 23 && alarm_minute <= 59) begin
        a_o = alarm_ore;
        a_m = alarm_minute;
      end
    end
`endif
    if (!reset) begin
      g_t = -100;
      m_valid = 0;
      last1 = 0;
      e_o1 = '0;
      e_o2 = '0;
      e_m1 = '0;
      e_m2 = '0;
    end else if (cyc > g_t + m_lat && (req1 || req2)) begin
      p2 = req2 && (!req1 || last1);
      last1 = !p2;
      o = p2 ? ore2 : ore1;
      m = p2 ? min2 : min1;
      ok = (o <= 23) && (m <= 59);
      m_who = p2 ? 2 : 1;
      m_valid = ok;
      g_t = cyc;
      m_lat = ok ? 2 + H : 1;
      if (ok && p2) begin
        e_o2 = o;
        e_m2 = m;
      end else if (ok) begin
        e_o1 = o;
        e_m1 = m;
      end
    end
  endtask

  task automatic check_outputs();
    chk("busy", busy, cyc > g_t && cyc <= g_t + m_lat);
    chk("load_1", load_1, m_valid && m_who == 1 && cyc == g_t + 1);
    chk("load_2", load_2, m_valid && m_who == 2 && cyc == g_t + 1);
    chk("ack1", ack1, m_valid && m_who == 1 && cyc == g_t + m_lat);
    chk("ack2", ack2, m_valid && m_who == 2 && cyc == g_t + m_lat);
    chk("nack1", nack1, !m_valid && m_who == 1 && cyc == g_t + 1);
    chk("nack2", nack2, !m_valid && m_who == 2 && cyc == g_t + 1);
    chk("timp_ore1", timp_ore1, e_o1);
    chk("timp_minute1", timp_minute1, e_m1);
    chk("timp_ore2", timp_ore2, e_o2);
    chk("timp_minute2", timp_minute2, e_m2);
    chk("exclusive", (load_1 & load_2) | ($countones({ack1, ack2, nack1, nack2}) > 1), 0);
`ifdef ALARM_EN
    chk("alarm", alarm, e_alarm);
`else
    chk("alarm", alarm, 0);
`endif
  endtask

  task automatic tick();
    model_step();
    @(negedge clock);
    cyc++;
    check_outputs();
  endtask

  initial begin
    reset = 0; req1 = 0; req2 = 0; ore1 = 0; ore2 = 0; min1 = 0; min2 = 0;
    out_ore = 0; out_minute = 0; alarm_set = 0; alarm_ore = 0; alarm_minute = 0;
    tick(); tick();
    reset = 1;
    req1 = 1; ore1 = 8; min1 = 30;
    tick();
    req1 = 0; ore1 = 31; min1 = 63;
    repeat (6) tick();
    reset = 0; tick(); reset = 1;
    req1 = 1; req2 = 1; ore1 = 10; min1 = 11; ore2 = 20; min2 = 22;
    repeat (12) tick();
    req1 = 0; req2 = 0;
    repeat (2) tick();
    req2 = 1; ore2 = 24; min2 = 10;
    tick();
    req2 = 0;
    repeat (3) tick();
    req2 = 1; ore2 = 12; min2 = 60;
    tick();
    req2 = 0;
    repeat (3) tick();
    req1 = 1; ore1 = 5; min1 = 5;
    tick();
    req1 = 0;
    tick();
    reset = 0;
    tick();
    reset = 1;
    tick();
    req1 = 1; ore1 = 7; min1 = 45;
    tick();
    req1 = 0;
    repeat (6) tick();
    out_ore = 16; out_minute = 44; alarm_set = 1; alarm_ore = 16; alarm_minute = 45;
    tick();
    alarm_set = 0;
    tick();
    out_minute = 45; tick(); tick();
    out_minute = 46; tick();
    alarm_set = 1; alarm_ore = 25; alarm_minute = 0;
    tick();
    alarm_set = 0; out_minute = 45;
    repeat (3) tick();
    repeat (3000) begin
      reset = ($urandom_range(0, 49) != 0);
      req1 = $urandom_range(0, 1) == 1;
      req2 = $urandom_range(0, 1) == 1;
      ore1 = 5'($urandom_range(0, 31));
      ore2 = 5'($urandom_range(0, 31));
      min1 = 6'($urandom_range(0, 63));
      min2 = 6'($urandom_range(0, 63));
      out_ore = 5'($urandom_range(16, 17));
      out_minute = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(44, 46));
      alarm_set = ($urandom_range(0, 15) == 0);
      alarm_ore = ($urandom_range(0, 3) == 0) ? 5'd25 : 5'($urandom_range(16, 17));
      alarm_minute = 6'($urandom_range(44, 46));
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
